dram_refresh_arbiter: RTL and testbench

Shares the DRAM array between CPU accesses from the fast-bus state machine and CAS-before-RAS refresh cycles. It generates refresh requests on a fixed interval and tracks refresh debt. It grants the array to the CPU or to a refresh sequence and drives the refresh-phase RAS/CAS strobes, which the DRAM control logic ORs into the array strobes. It sits between the fast-bus controller and the DRAM strobe/mux logic, in the FCLK domain.

---
 rtl/fsb_pkg.sv | 30 +++
 rtl/refresh_timer.sv | 41 ++++
 rtl/dram_refresh_arbiter.sv | 131 +++++++++++++
 tb/tb_dram_refresh_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsb_pkg.sv
// Shared fast-bus types and default DRAM timing constants for the arbiter and DRAM control block.
package fsb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CPU   = 3'd1,
    CAS   = 3'd2,
    RAS   = 3'd3,
    PRECH = 3'd4
  } arbState_t;

  // Records what the current precharge follows; a refresh precharge keeps RefBusy high.
  typedef enum logic {
    PRECH_CPU = 1'b0,
    PRECH_REF = 1'b1
  } prechFromRef_t;

  localparam int unsigned DEF_REF_INTERVAL  = 125;
  localparam int unsigned DEF_REF_PEND_MAX  = 4;
  localparam int unsigned DEF_URGENT_THRESH = 2;
  localparam int unsigned DEF_RAS_CYCLES    = 4;
  localparam int unsigned DEF_PRECH_CYCLES  = 2;

  function automatic int unsigned cntWidth(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/refresh_timer.sv
// Refresh interval timer with tick generation, saturating refresh-debt counter and sticky overflow.
module refresh_timer
  import fsb_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int unsigned REF_PEND_MAX = DEF_REF_PEND_MAX
) (
  input  logic       FCLK,
  input  logic       RES,
  input  logic       refDone,
  output logic [2:0] RefPend,
  output logic       RefOvf
);

  localparam int unsigned TW = $clog2(REF_INTERVAL);

  logic [TW-1:0] timer;
  logic          tick;

  assign tick = (timer == TW'(REF_INTERVAL - 1));

  always_ff @(posedge FCLK) begin
    if (RES) begin
      timer   <= '0;
      RefPend <= '0;
      RefOvf  <= 1'b0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      // A tick coinciding with a completion cancels out: no change, no overflow.
      if (tick && !refDone) begin
        if (RefPend == 3'(REF_PEND_MAX))
          RefOvf <= 1'b1;
        else
          RefPend <= RefPend + 1'b1;
      end else if (!tick && refDone && (RefPend != '0)) begin
        RefPend <= RefPend - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_refresh_arbiter.sv
// Arbitrates the DRAM array between CPU cycles and CAS-before-RAS refresh; drives refresh strobes.
// Optional back-to-back refresh draining when REF_BURST_EN is defined.
module dram_refresh_arbiter
  import fsb_pkg::*;
#(
  parameter int unsigned REF_INTERVAL  = DEF_REF_INTERVAL,
  parameter int unsigned REF_PEND_MAX  = DEF_REF_PEND_MAX,
  parameter int unsigned URGENT_THRESH = DEF_URGENT_THRESH,
  parameter int unsigned RAS_CYCLES    = DEF_RAS_CYCLES,
  parameter int unsigned PRECH_CYCLES  = DEF_PRECH_CYCLES
) (
  input  logic       FCLK,
  input  logic       RES,
  input  logic       CPUReq,
  input  logic       CPUDone,
  output logic       CPUGnt,
  output logic       RefBusy,
  output logic       RefCAS,
  output logic       RefRAS,
  output logic [2:0] RefPend,
  output logic       RefOvf
);

  localparam int unsigned CNT_W = cntWidth(RAS_CYCLES, PRECH_CYCLES);

  arbState_t     state, stateNext;
  prechFromRef_t prechSrc, prechSrcNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic cntZero;
  logic refDone;
  logic gntNext, busyNext, casNext, rasNext;

  refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL),
    .REF_PEND_MAX(REF_PEND_MAX)
  ) uTimer (
    .FCLK   (FCLK),
    .RES    (RES),
    .refDone(refDone),
    .RefPend(RefPend),
    .RefOvf (RefOvf)
  );

  assign cntZero = (cnt == '0);
  assign refDone = (state == RAS) && cntZero;

  always_comb begin
    stateNext    = state;
    prechSrcNext = prechSrc;
    cntNext      = cnt;
    case (state)
      IDLE: begin
        cntNext = '0;
        if (RefPend >= 3'(URGENT_THRESH))
          stateNext = CAS;
        else if (CPUReq)
          stateNext = CPU;
        else if (RefPend != '0)
          stateNext = CAS;
      end
      CPU: begin
        if (CPUDone) begin
          stateNext    = PRECH;
          prechSrcNext = PRECH_CPU;
          cntNext      = CNT_W'(PRECH_CYCLES - 1);
        end
      end
      CAS: begin
        stateNext = RAS;
        cntNext   = CNT_W'(RAS_CYCLES - 1);
      end
      RAS: begin
        if (cntZero) begin
          stateNext    = PRECH;
          prechSrcNext = PRECH_REF;
          cntNext      = CNT_W'(PRECH_CYCLES - 1);
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      PRECH: begin
        if (cntZero) begin
          cntNext = '0;
`ifdef REF_BURST_EN
          if ((prechSrc == PRECH_REF) && (RefPend != '0) && !CPUReq)
            stateNext = CAS;
          else
            stateNext = IDLE;
`else
          stateNext = IDLE;
`endif
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_comb begin
    gntNext  = (stateNext == CPU);
    casNext  = (stateNext == CAS) || (stateNext == RAS);
    rasNext  = (stateNext == RAS);
    busyNext = casNext || ((stateNext == PRECH) && (prechSrcNext == PRECH_REF));
  end

  always_ff @(posedge FCLK) begin
    if (RES) begin
      state    <= IDLE;
      prechSrc <= PRECH_CPU;
      cnt      <= '0;
      CPUGnt   <= 1'b0;
      RefBusy  <= 1'b0;
      RefCAS   <= 1'b0;
      RefRAS   <= 1'b0;
    end else begin
      state    <= stateNext;
      prechSrc <= prechSrcNext;
      cnt      <= cntNext;
      CPUGnt   <= gntNext;
      RefBusy  <= busyNext;
      RefCAS   <= casNext;
      RefRAS   <= rasNext;
    end
  end

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Directed bench for dram_refresh_arbiter with REF_INTERVAL=16; honours REF_BURST_EN.
module tb_dram_refresh_arbiter;

  logic       FCLK = 1'b0;
  logic       RES = 1'b0;
  logic       CPUReq = 1'b0;
  logic       CPUDone = 1'b0;
  logic       CPUGnt, RefBusy, RefCAS, RefRAS, RefOvf;
  logic [2:0] RefPend;

  int checks = 0;
  int failures = 0;

  dram_refresh_arbiter #(
    .REF_INTERVAL (16),
    .REF_PEND_MAX (4),
    .URGENT_THRESH(2),
    .RAS_CYCLES   (4),
    .PRECH_CYCLES (2)
  ) dut (
    .FCLK   (FCLK),
    .RES    (RES),
    .CPUReq (CPUReq),
    .CPUDone(CPUDone),
    .CPUGnt (CPUGnt),
    .RefBusy(RefBusy),
    .RefCAS (RefCAS),
    .RefRAS (RefRAS),
    .RefPend(RefPend),
    .RefOvf (RefOvf)
  );

  always #5 FCLK = ~FCLK;

  task automatic step();
    @(posedge FCLK);
    #1;
  endtask

  task automatic do_reset();
    CPUReq = 1'b0;
    CPUDone = 1'b0;
    RES = 1'b1;
    step();
    RES = 1'b0;
  endtask

  task automatic test_reset();
    CPUReq = 1'b1;
    RES = 1'b1;
    step();
    checks++;
    if ({CPUGnt, RefBusy, RefCAS, RefRAS, RefPend, RefOvf} !== 8'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {CPUGnt, RefBusy, RefCAS, RefRAS, RefPend, RefOvf}, 8'b0);
    end
    RES = 1'b0;
    CPUReq = 1'b0;
  endtask

  task automatic test_idle_refresh();
    logic [3:0] exp;
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      step();
      exp = 4'b0000;
      if (k == 17 || k == 33) exp = 4'b0110;
      else if ((k >= 18 && k <= 21) || k == 34) exp = 4'b0111;
      else if (k == 22 || k == 23) exp = 4'b0100;
      checks++;
      if ({CPUGnt, RefBusy, RefCAS, RefRAS} !== exp) begin
        failures++;
        $display("FAIL idle_refresh cyc=%0d gnt/busy/cas/ras got=%b exp=%b", k, {CPUGnt, RefBusy, RefCAS, RefRAS}, exp);
      end
      if (k == 16 || k == 22 || k == 32) begin
        checks++;
        if (RefPend !== ((k == 22) ? 3'd0 : 3'd1)) begin
          failures++;
          $display("FAIL idle_refresh_pend cyc=%0d got=%0d exp=%0d", k, RefPend, (k == 22) ? 0 : 1);
        end
      end
    end
  endtask

  task automatic test_cpu_priority();
    logic [3:0] exp;
    do_reset();
    for (int k = 1; k <= 23; k++) begin
      step();
      exp = 4'b0000;
      if (k >= 17 && k <= 19) exp = 4'b1000;
      else if (k == 23) exp = 4'b0110;
      checks++;
      if ({CPUGnt, RefBusy, RefCAS, RefRAS} !== exp) begin
        failures++;
        $display("FAIL cpu_priority cyc=%0d gnt/busy/cas/ras got=%b exp=%b", k, {CPUGnt, RefBusy, RefCAS, RefRAS}, exp);
      end
      // CPUDone while idle must be ignored; later the real CPU cycle ends.
      if (k == 2) CPUDone = 1'b1;
      if (k == 3) CPUDone = 1'b0;
      if (k == 16) CPUReq = 1'b1;
      if (k == 19) begin CPUReq = 1'b0; CPUDone = 1'b1; end
      if (k == 20) CPUDone = 1'b0;
    end
  endtask

  task automatic test_urgent_preempt();
    logic [3:0] exp;
    do_reset();
    CPUReq = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      step();
      exp = 4'b0000;
      if (k <= 32 || k == 44) exp = 4'b1000;
      else if (k == 36) exp = 4'b0110;
      else if (k >= 37 && k <= 40) exp = 4'b0111;
      else if (k == 41 || k == 42) exp = 4'b0100;
      checks++;
      if ({CPUGnt, RefBusy, RefCAS, RefRAS} !== exp) begin
        failures++;
        $display("FAIL urgent_preempt cyc=%0d gnt/busy/cas/ras got=%b exp=%b", k, {CPUGnt, RefBusy, RefCAS, RefRAS}, exp);
      end
      if (k == 32 || k == 41) begin
        checks++;
        if (RefPend !== ((k == 32) ? 3'd2 : 3'd1)) begin
          failures++;
          $display("FAIL urgent_preempt_pend cyc=%0d got=%0d exp=%0d", k, RefPend, (k == 32) ? 2 : 1);
        end
      end
      if (k == 32) CPUDone = 1'b1;
      if (k == 33) CPUDone = 1'b0;
    end
    CPUReq = 1'b0;
    CPUDone = 1'b1;
    step();
    CPUDone = 1'b0;
  endtask

  task automatic test_saturation();
    bit drained;
    do_reset();
    CPUReq = 1'b1;
    for (int k = 1; k <= 96; k++) begin
      step();
      if (k == 64 || k == 80 || k == 96) begin
        checks++;
        if ({CPUGnt, RefPend, RefOvf} !== {1'b1, 3'd4, (k != 64)}) begin
          failures++;
          $display("FAIL saturation cyc=%0d gnt/pend/ovf got=%b/%0d/%b exp=1/4/%b", k, CPUGnt, RefPend, RefOvf, (k != 64));
        end
      end
    end
    CPUReq = 1'b0;
    CPUDone = 1'b1;
    step();
    CPUDone = 1'b0;
    drained = 1'b0;
    for (int n = 0; n < 200 && !drained; n++) begin
      step();
      if (RefPend == 3'd0) drained = 1'b1;
    end
    checks++;
    if (!drained) begin
      failures++;
      $display("FAIL saturation_drain timeout RefPend=%0d exp=0", RefPend);
    end
    checks++;
    if (RefOvf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=1", RefOvf);
    end
    RES = 1'b1;
    step();
    RES = 1'b0;
    checks++;
    if (RefOvf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", RefOvf);
    end
  endtask

  task automatic test_tick_and_done();
    do_reset();
    CPUReq = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k == 47) begin
        checks++;
        if ({RefRAS, RefPend} !== {1'b1, 3'd2}) begin
          failures++;
          $display("FAIL tick_done_pre ras/pend got=%b/%0d exp=1/2", RefRAS, RefPend);
        end
      end
      if (k == 48) begin
        checks++;
        if ({RefRAS, RefBusy, RefPend, RefOvf} !== {1'b0, 1'b1, 3'd2, 1'b0}) begin
          failures++;
          $display("FAIL tick_done ras/busy/pend/ovf got=%b/%b/%0d/%b exp=0/1/2/0", RefRAS, RefBusy, RefPend, RefOvf);
        end
      end
      if (k == 39) begin CPUReq = 1'b0; CPUDone = 1'b1; end
      if (k == 40) CPUDone = 1'b0;
    end
  endtask

  task automatic test_reset_mid_ras();
    do_reset();
    for (int k = 1; k <= 19; k++) step();
    checks++;
    if (RefRAS !== 1'b1) begin
      failures++;
      $display("FAIL mid_ras_setup RefRAS got=%b exp=1", RefRAS);
    end
    RES = 1'b1;
    step();
    RES = 1'b0;
    checks++;
    if ({CPUGnt, RefBusy, RefCAS, RefRAS, RefPend, RefOvf} !== 8'b0) begin
      failures++;
      $display("FAIL mid_ras_reset got=%b exp=%b", {CPUGnt, RefBusy, RefCAS, RefRAS, RefPend, RefOvf}, 8'b0);
    end
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15 || k == 16) begin
        checks++;
        if (RefPend !== ((k == 16) ? 3'd1 : 3'd0)) begin
          failures++;
          $display("FAIL timer_restart cyc=%0d pend got=%0d exp=%0d", k, RefPend, (k == 16) ? 1 : 0);
        end
      end
      if (k == 17) begin
        checks++;
        if ({RefBusy, RefCAS, RefRAS} !== 3'b110) begin
          failures++;
          $display("FAIL timer_restart_cas got=%b exp=110", {RefBusy, RefCAS, RefRAS});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    do_reset();
    CPUReq = 1'b1;
    for (int k = 1; k <= 49; k++) step();
    checks++;
    if (RefPend !== 3'd3) begin
      failures++;
      $display("FAIL b2b_setup pend got=%0d exp=3", RefPend);
    end
    CPUReq = 1'b0;
    CPUDone = 1'b1;
    for (int k = 50; k <= 69; k++) begin
      step();
      CPUDone = 1'b0;
      exp = 4'b0000;
`ifdef REF_BURST_EN
      if (k == 53 || k == 60 || k == 67) exp = 4'b0110;
      else if ((k >= 54 && k <= 57) || (k >= 61 && k <= 64) || k >= 68) exp = 4'b0111;
      else if (k == 58 || k == 59 || k == 65 || k == 66) exp = 4'b0100;
`else
      if (k == 53 || k == 61 || k == 69) exp = 4'b0110;
      else if ((k >= 54 && k <= 57) || (k >= 62 && k <= 65)) exp = 4'b0111;
      else if (k == 58 || k == 59 || k == 66 || k == 67) exp = 4'b0100;
`endif
      checks++;
      if ({CPUGnt, RefBusy, RefCAS, RefRAS} !== exp) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d gnt/busy/cas/ras got=%b exp=%b", k, {CPUGnt, RefBusy, RefCAS, RefRAS}, exp);
      end
      if (k == 58) begin
        checks++;
        if (RefPend !== 3'd2) begin
          failures++;
          $display("FAIL back_to_back_pend got=%0d exp=2", RefPend);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_refresh();
    test_cpu_priority();
    test_urgent_preempt();
    test_saturation();
    test_tick_and_done();
    test_reset_mid_ras();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
